// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with RoB-tag renaming
//
// Purpose:
//   Holds REG_NUM x DATA_W integer registers. Each register also has a busy
//   flag and the RoB slot (tag) of its newest in-flight producer. Issue
//   renames rd to a RoB slot. Commit writes the value back, and clears busy
//   only when the committing slot is still the newest producer. Source lookups
//   are combinational and forward a same-cycle matching commit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global ready; all state holds while low
//   rollback            flush: clears every busy flag, drops same-cycle issue
//   issue, issue_rd, issue_rob_pos
//                       rename issue_rd to RoB slot issue_rob_pos
//   commit_reg, commit_reg_rd, commit_reg_val, commit_rob_pos
//                       write back a committed result
//   rs1/rs2             source indices
//   rsN_busy/val/rob_pos
//                       source lookup results (val valid when !busy,
//                       rob_pos valid when busy)

module reg_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       rollback,
    input  logic                       issue,
    input  logic [$clog2(REG_NUM)-1:0] issue_rd,
    input  logic [ROB_W-1:0]           issue_rob_pos,
    input  logic                       commit_reg,
    input  logic [$clog2(REG_NUM)-1:0] commit_reg_rd,
    input  logic [DATA_W-1:0]          commit_reg_val,
    input  logic [ROB_W-1:0]           commit_rob_pos,
    input  logic [$clog2(REG_NUM)-1:0] rs1,
    output logic                       rs1_busy,
    output logic [DATA_W-1:0]          rs1_val,
    output logic [ROB_W-1:0]           rs1_rob_pos,
    input  logic [$clog2(REG_NUM)-1:0] rs2,
    output logic                       rs2_busy,
    output logic [DATA_W-1:0]          rs2_val,
    output logic [ROB_W-1:0]           rs2_rob_pos
);

    localparam int IDX_W = $clog2(REG_NUM);

    logic [DATA_W-1:0] val_q [REG_NUM];
    logic [DATA_W-1:0] val_d [REG_NUM];
    logic [ROB_W-1:0]  tag_q [REG_NUM];
    logic [ROB_W-1:0]  tag_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic commit_en;
    logic issue_en;

    // x0 is hard-wired: neither commit nor issue ever touches it.
    assign commit_en = commit_reg && (commit_reg_rd != '0);
    assign issue_en  = issue && !rollback && (issue_rd != '0);

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;

        if (rdy) begin
            if (commit_en) begin
                val_d[commit_reg_rd] = commit_reg_val;
                // Only the newest producer may clear busy; an older commit
                // to a re-renamed register leaves the younger mapping alone.
                if (busy_q[commit_reg_rd] &&
                    (tag_q[commit_reg_rd] == commit_rob_pos)) begin
                    busy_d[commit_reg_rd] = 1'b0;
                end
            end

            // Flush drops every rename; committed values stay.
            if (rollback) begin
                busy_d = '0;
            end

            // Applied last so a same-rd issue wins over the commit clear.
            if (issue_en) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_pos;
            end
        end

        val_d[0]  = '0;
        tag_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source lookups. They see committed state plus a same-cycle commit
    // from the current producer, never the same-cycle issue, so an
    // instruction with rd==rs reads the previous mapping.
    // ------------------------------------------------------------------
    logic fwd1;
    logic fwd2;

    assign fwd1 = busy_q[rs1] && commit_reg && (commit_reg_rd == rs1) &&
                  (commit_rob_pos == tag_q[rs1]);
    assign fwd2 = busy_q[rs2] && commit_reg && (commit_reg_rd == rs2) &&
                  (commit_rob_pos == tag_q[rs2]);

    always_comb begin
        rs1_busy    = 1'b0;
        rs1_val     = '0;
        rs1_rob_pos = '0;
        if (rs1 != IDX_W'(0)) begin
            rs1_rob_pos = tag_q[rs1];
            if (fwd1) begin
                rs1_val = commit_reg_val;
            end else begin
                rs1_busy = busy_q[rs1];
                rs1_val  = val_q[rs1];
            end
        end
    end

    always_comb begin
        rs2_busy    = 1'b0;
        rs2_val     = '0;
        rs2_rob_pos = '0;
        if (rs2 != IDX_W'(0)) begin
            rs2_rob_pos = tag_q[rs2];
            if (fwd2) begin
                rs2_val = commit_reg_val;
            end else begin
                rs2_busy = busy_q[rs2];
                rs2_val  = val_q[rs2];
            end
        end
    end

endmodule
